// File: rtl/snake_body_engine.sv
// Snake body engine: keeps the snake's segments in a ring buffer and issues
// single-bit bitmap RAM writes for clear, initial placement and each move.
module snake_body_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] forward,
  input  logic [3:0] mode,
  input  logic       grow,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic       wr_data,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [6:0] len,
  output logic       busy,
  output logic       done,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  // Ring pointers wrap naturally, so MAX_LEN is expected to be a power of two.
  localparam int PW      = $clog2(MAX_LEN);
  localparam int CELLS   = GRID_W * GRID_H;
  localparam int INIT_X0 = GRID_W / 2 - INIT_LEN + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_INIT, S_CALC, S_CHECK, S_WR_HEAD, S_CLR_TAIL, S_DONE
  } state_t;

  state_t state, state_n;

  logic [9:0]    clr_addr;
  logic [6:0]    init_idx;
  logic [6:0]    chk_idx;
  logic [PW-1:0] head_ptr;
  logic          grow_l;
  logic [1:0]    fwd_l;
  logic [4:0]    new_x, new_y;
  logic [4:0]    tail_x, tail_y;
  logic [6:0]    len_q;
  logic [4:0]    hx, hy;
  logic          go;

  logic [4:0]    ring_x [MAX_LEN];
  logic [4:0]    ring_y [MAX_LEN];

  logic          cmd_reset, cmd_move;
  logic [6:0]    ncmp;
  logic [PW-1:0] cmp_idx, tail_idx;
  logic          hit;
  logic [4:0]    init_x, calc_x, calc_y;

  function automatic logic [9:0] addr_of(input logic [4:0] x, input logic [4:0] y);
    return 10'(y) * 10'(GRID_W) + 10'(x);
  endfunction

  assign cmd_reset = en && (mode == 4'd0);
  assign cmd_move  = en && (mode == 4'd1) && (state == S_IDLE) && (len_q != 7'd0) && !go;

  // grow_l already folds in the full-length case, so it alone selects the count.
  assign ncmp     = grow_l ? len_q : len_q - 7'd1;
  assign cmp_idx  = head_ptr - chk_idx[PW-1:0];
  assign tail_idx = head_ptr - len_q[PW-1:0] + PW'(1);
  assign hit      = (ring_x[cmp_idx] == new_x) && (ring_y[cmp_idx] == new_y);
  assign init_x   = 5'(INIT_X0) + init_idx[4:0];

  always_comb begin
    calc_x = hx;
    calc_y = hy;
    case (fwd_l)
      2'b00:   calc_x = (hx == 5'(GRID_W - 1)) ? 5'd0 : hx + 5'd1;
      2'b01:   calc_x = (hx == 5'd0) ? 5'(GRID_W - 1) : hx - 5'd1;
      2'b10:   calc_y = (hy == 5'(GRID_H - 1)) ? 5'd0 : hy + 5'd1;
      default: calc_y = (hy == 5'd0) ? 5'(GRID_H - 1) : hy - 5'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wr_addr = 10'd0;
    wr_data = 1'b0;
    case (state)
      S_IDLE:  if (cmd_move) state_n = S_CALC;
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        if (clr_addr == 10'(CELLS - 1)) state_n = S_INIT;
      end
      S_INIT: begin
        wr_en   = 1'b1;
        wr_addr = addr_of(init_x, 5'(GRID_H / 2));
        wr_data = 1'b1;
        if (init_idx == 7'(INIT_LEN - 1)) state_n = S_DONE;
      end
      S_CALC:  state_n = (ncmp == 7'd0) ? S_WR_HEAD : S_CHECK;
      S_CHECK: begin
        if (hit)                          state_n = S_DONE;
        else if (chk_idx == ncmp - 7'd1)  state_n = S_WR_HEAD;
      end
      S_WR_HEAD: begin
        wr_en   = 1'b1;
        wr_addr = addr_of(new_x, new_y);
        wr_data = 1'b1;
        state_n = grow_l ? S_DONE : S_CLR_TAIL;
      end
      S_CLR_TAIL: begin
        wr_en   = 1'b1;
        wr_addr = addr_of(tail_x, tail_y);
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (cmd_reset) state_n = S_CLEAR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_addr <= 10'd0;
      init_idx <= 7'd0;
      chk_idx  <= 7'd0;
      head_ptr <= '0;
      grow_l   <= 1'b0;
      fwd_l    <= 2'd0;
      new_x    <= 5'd0;
      new_y    <= 5'd0;
      tail_x   <= 5'd0;
      tail_y   <= 5'd0;
      len_q    <= 7'd0;
      hx       <= 5'd0;
      hy       <= 5'd0;
      go       <= 1'b0;
    end else if (cmd_reset) begin
      clr_addr <= 10'd0;
      init_idx <= 7'd0;
      head_ptr <= '0;
      len_q    <= 7'd0;
      go       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_move) begin
          grow_l <= grow && (len_q < 7'(MAX_LEN));
          fwd_l  <= forward;
        end
        S_CLEAR: clr_addr <= clr_addr + 10'd1;
        S_INIT: begin
          head_ptr <= init_idx[PW-1:0];
          hx       <= init_x;
          hy       <= 5'(GRID_H / 2);
          len_q    <= init_idx + 7'd1;
          init_idx <= init_idx + 7'd1;
        end
        S_CALC: begin
          // The tail is captured now because a full ring overwrites its slot in WR_HEAD.
          new_x   <= calc_x;
          new_y   <= calc_y;
          tail_x  <= ring_x[tail_idx];
          tail_y  <= ring_y[tail_idx];
          chk_idx <= 7'd0;
        end
        S_CHECK: begin
          if (hit) go <= 1'b1;
          else     chk_idx <= chk_idx + 7'd1;
        end
        S_WR_HEAD: begin
          head_ptr <= head_ptr + PW'(1);
          hx       <= new_x;
          hy       <= new_y;
          if (grow_l) len_q <= len_q + 7'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      ring_x[init_idx[PW-1:0]] <= init_x;
      ring_y[init_idx[PW-1:0]] <= 5'(GRID_H / 2);
    end else if (state == S_WR_HEAD) begin
      ring_x[head_ptr + PW'(1)] <= new_x;
      ring_y[head_ptr + PW'(1)] <= new_y;
    end
  end

  assign head_x    = hx;
  assign head_y    = hy;
  assign len       = len_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign game_over = go;
  assign state_dbg = state;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: expected bitmap writes go into a queue that a
// negedge monitor drains; command results are checked after each done pulse.
module tb_snake_body_engine;

  localparam int GW = 32;
  localparam int GH = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] forward = 2'd0;
  logic [3:0] mode = 4'd0;
  logic       grow = 1'b0;
  logic       wr_en, wr_data, busy, done, game_over;
  logic [9:0] wr_addr;
  logic [4:0] head_x, head_y;
  logic [6:0] len;
  logic [2:0] state_dbg;

  snake_body_engine dut (
    .clk(clk), .rst(rst), .en(en), .forward(forward), .mode(mode), .grow(grow),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .head_x(head_x), .head_y(head_y), .len(len),
    .busy(busy), .done(done), .game_over(game_over), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [10:0] exp_q[$];
  logic [9:0]  body_q[$];
  bit          go_exp = 1'b0;
  logic [10:0] mon_got, mon_exp;

  function automatic int baddr(input int x, input int y);
    return y * GW + x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mon_got = {wr_data, wr_addr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, nothing expected", wr_addr, wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL bitmap_write: got addr %0d data %0d expected addr %0d data %0d",
                   mon_got[9:0], mon_got[10], mon_exp[9:0], mon_exp[10]);
        end
      end
    end
  end

  // driver tasks
  task automatic do_cmd(input logic [3:0] m, input logic [1:0] f, input logic g);
    @(negedge clk);
    mode = m; forward = f; grow = g; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) break;
    end
    chk("done_seen", int'(done), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic push_clear_and_init();
    for (int a = 0; a < GW * GH; a++) exp_q.push_back({1'b0, 10'(a)});
    for (int x = 14; x <= 16; x++) exp_q.push_back({1'b1, 10'(baddr(x, 12))});
  endtask

  task automatic check_after_init(input int lat, input int exp_lat);
    chk("init_latency", lat, exp_lat);
    chk("init_len", int'(len), 3);
    chk("init_head_x", int'(head_x), 16);
    chk("init_head_y", int'(head_y), 12);
    chk("init_queue_drained", exp_q.size(), 0);
    body_q = {};
    for (int x = 14; x <= 16; x++) body_q.push_back({5'(x), 5'd12});
    go_exp = 1'b0;
  endtask

  task automatic init_snake();
    int lat;
    push_clear_and_init();
    do_cmd(4'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("clear_busy", int'(busy), 1);
    chk("clear_game_over", int'(game_over), 0);
    wait_done(lat);
    check_after_init(lat, 771);
  endtask

  task automatic move(input logic [1:0] f, input logic g, input int exp_lat, input bit collide);
    int hx, hy, nx, ny, lat;
    logic [9:0] t;
    t = body_q[body_q.size() - 1];
    hx = int'(t[9:5]); hy = int'(t[4:0]);
    nx = hx; ny = hy;
    case (f)
      2'b00:   nx = (hx == GW - 1) ? 0 : hx + 1;
      2'b01:   nx = (hx == 0) ? GW - 1 : hx - 1;
      2'b10:   ny = (hy == GH - 1) ? 0 : hy + 1;
      default: ny = (hy == 0) ? GH - 1 : hy - 1;
    endcase
    if (collide) go_exp = 1'b1;
    else begin
      exp_q.push_back({1'b1, 10'(baddr(nx, ny))});
      if (!(g && body_q.size() < 64)) begin
        t = body_q.pop_front();
        exp_q.push_back({1'b0, 10'(baddr(int'(t[9:5]), int'(t[4:0])))});
      end
      body_q.push_back({5'(nx), 5'(ny)});
    end
    do_cmd(4'd1, f, g);
    wait_done(lat);
    t = body_q[body_q.size() - 1];
    chk("move_latency", lat, exp_lat);
    chk("move_head_x", int'(head_x), int'(t[9:5]));
    chk("move_head_y", int'(head_y), int'(t[4:0]));
    chk("move_len", int'(len), body_q.size());
    chk("move_game_over", int'(game_over), int'(go_exp));
    chk("move_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, done_cnt;
    #12;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_len", int'(len), 0);
    chk("rst_head_x", int'(head_x), 0);
    chk("rst_head_y", int'(head_y), 0);
    @(negedge clk);
    rst = 1'b1;

    init_snake();
    move(2'b00, 1'b0, 6, 1'b0);

    do_cmd(4'd7, 2'd0, 1'b0);
    @(negedge clk);
    chk("other_mode_busy", int'(busy), 0);

    init_snake();
    move(2'b00, 1'b1, 6, 1'b0);
    move(2'b00, 1'b1, 7, 1'b0);
    move(2'b10, 1'b0, 8, 1'b0);
    move(2'b01, 1'b0, 8, 1'b0);
    move(2'b11, 1'b0, 6, 1'b1);

    do_cmd(4'd1, 2'b00, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("ignored_move_busy", int'(busy), 0);
    chk("ignored_move_done", done_cnt, 0);
    chk("ignored_move_game_over", int'(game_over), 1);

    init_snake();
    for (int i = 0; i < 16; i++) move(2'b00, 1'b0, 6, 1'b0);
    chk("x_wrap_head_x", int'(head_x), 0);
    for (int i = 0; i < 13; i++) move(2'b11, 1'b0, 6, 1'b0);
    chk("y_wrap_head_y", int'(head_y), 23);

    for (int a = 0; a < 22; a++) exp_q.push_back({1'b0, 10'(a)});
    push_clear_and_init();
    do_cmd(4'd0, 2'd0, 1'b0);
    do_cmd(4'd1, 2'b00, 1'b0);
    chk("busy_move_busy", int'(busy), 1);
    repeat (20) @(negedge clk);
    do_cmd(4'd0, 2'd0, 1'b0);
    wait_done(lat);
    check_after_init(lat, 772);

    for (int a = 0; a < 5; a++) exp_q.push_back({1'b0, 10'(a)});
    do_cmd(4'd0, 2'd0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_queue_drained", exp_q.size(), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_len", int'(len), 0);
    chk("midrst_head_x", int'(head_x), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
